// File: rtl/mmio_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : mmio_pkg                                                     |
// | Purpose : Shared constants for the MMIO controller: the I/O region tag  |
// |           (top two address bits) and the register word offsets within  |
// |           that region.                                                 |
// | Ports   : none (package)                                               |
// | Rev     : 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
package mmio_pkg;

  // Top two address bits that select the I/O region
  localparam logic [1:0] IO_TAG     = 2'b11;

  // Register word offsets, decoded from cpu_addr[3:0]
  localparam logic [3:0] OFF_OUT    = 4'd0;   // OUT[0..NUM_OUT-1], load
  localparam logic [3:0] OFF_SET    = 4'd4;   // OUT[0..NUM_OUT-1], OR-in alias
  localparam logic [3:0] OFF_IN     = 4'd8;   // debounced inputs, read-only
  localparam logic [3:0] OFF_STATUS = 4'd9;   // sticky rising edges, W1C
  localparam logic [3:0] OFF_ENABLE = 4'd10;  // interrupt enable mask

endpackage
`default_nettype wire

// File: rtl/mmio_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : mmio_if                                                      |
// | Purpose : CPU data port / BRAM port bundle seen by the MMIO controller. |
// | Ports   : cpu_addr, cpu_wdata, cpu_we  - CPU request                   |
// |           cpu_rdata                    - read data back to the CPU     |
// |           mem_q                        - BRAM read data (1-cycle lat.) |
// |           mem_we                       - gated BRAM write enable       |
// |           modport master: CPU/BRAM side, modport slave: controller     |
// | Rev     : 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
interface mmio_if #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 16
);

  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [WIDTH-1:0]      cpu_wdata;
  logic                  cpu_we;
  logic [WIDTH-1:0]      cpu_rdata;
  logic [WIDTH-1:0]      mem_q;
  logic                  mem_we;

  modport master (
    output cpu_addr, cpu_wdata, cpu_we, mem_q,
    input  cpu_rdata, mem_we
  );

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_we, mem_q,
    output cpu_rdata, mem_we
  );

endinterface
`default_nettype wire

// File: rtl/input_debounce.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : input_debounce                                               |
// | Purpose : Two-flop synchronizer per input line followed by one shared  |
// |           stability counter. A change is accepted into 'stable' only   |
// |           after DEBOUNCE_CYCLES consecutive cycles of disagreement.    |
// | Ports   : clk, reset (sync, active-low)                                |
// |           switches - asynchronous input lines                          |
// |           stable   - debounced level                                   |
// |           rise     - bits about to go 0->1 at the next clock edge      |
// | Rev     : 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module input_debounce #(
  parameter int IN_WIDTH        = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  wire logic                clk,
  input  wire logic                reset,
  input  wire logic [IN_WIDTH-1:0] switches,
  output logic      [IN_WIDTH-1:0] stable,
  output logic      [IN_WIDTH-1:0] rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [IN_WIDTH-1:0] r_sync1;
  logic [IN_WIDTH-1:0] r_sync2;
  logic [IN_WIDTH-1:0] r_stable;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_differs;
  logic                w_accept;
  logic [IN_WIDTH-1:0] w_stable_next;

  assign w_differs     = (r_sync2 != r_stable);
  assign w_accept      = w_differs && (r_cnt == C_CNT_MAX);
  assign w_stable_next = w_accept ? r_sync2 : r_stable;

  // rise looks one edge ahead so the sticky status register can capture
  // the edge on the same clock that updates the stable level.
  assign stable = r_stable;
  assign rise   = w_stable_next & ~r_stable;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_stable <= '0;
      r_cnt    <= '0;
    end else begin
      r_sync1  <= switches;
      r_sync2  <= r_sync1;
      r_stable <= w_stable_next;
      if (!w_differs || w_accept) begin
        r_cnt <= '0;
      end else if (r_cnt != C_CNT_MAX) begin
        // Never wraps: reaching the maximum always accepts and clears.
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mmio_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : mmio_ctrl                                                    |
// | Purpose : Memory-mapped I/O controller between CPU data port and BRAM. |
// |           Addresses with the top two bits == 2'b11 hit the I/O region; |
// |           BRAM writes there are blocked. Holds NUM_OUT output regs,    |
// |           debounced inputs, sticky rising-edge status with enable mask |
// |           and a level interrupt. Read data for both sources arrives    |
// |           one cycle after the address.                                 |
// | Ports   : clk, reset (sync, active-low)                                |
// |           bus      - mmio_if.slave (CPU request, BRAM q/we, rdata)     |
// |           switches - asynchronous input lines                          |
// |           leds     - output registers, bank i at [i*OUT_WIDTH +: ..]   |
// |           irq      - registered |(STATUS & ENABLE)                     |
// | Rev     : 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module mmio_ctrl
  import mmio_pkg::*;
#(
  parameter int WIDTH           = 16,
  parameter int ADDR_WIDTH      = 16,
  parameter int NUM_OUT         = 2,
  parameter int OUT_WIDTH       = 8,
  parameter int IN_WIDTH        = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  wire logic                         clk,
  input  wire logic                         reset,
  mmio_if.slave                             bus,
  input  wire logic [IN_WIDTH-1:0]          switches,
  output logic      [NUM_OUT*OUT_WIDTH-1:0] leds,
  output logic                              irq
);

  logic                 w_io_hit;
  logic [3:0]           w_off;
  logic                 w_io_we;
  logic [IN_WIDTH-1:0]  w_stable;
  logic [IN_WIDTH-1:0]  w_rise;
  logic [IN_WIDTH-1:0]  w_clr;
  logic [WIDTH-1:0]     w_io_data;
  logic                 w_unused;

  logic [OUT_WIDTH-1:0] r_out [NUM_OUT];
  logic [IN_WIDTH-1:0]  r_status;
  logic [IN_WIDTH-1:0]  r_enable;
  logic                 r_irq;
  logic                 r_sel_q;
  logic [WIDTH-1:0]     r_io_q;

  // Decode
  assign w_io_hit   = (bus.cpu_addr[ADDR_WIDTH-1 -: 2] == IO_TAG);
  assign w_off      = bus.cpu_addr[3:0];
  assign w_io_we    = bus.cpu_we & w_io_hit;
  assign bus.mem_we = bus.cpu_we & ~w_io_hit;

  // Middle address bits and upper data bits are intentionally ignored.
  assign w_unused = ^{bus.cpu_addr, bus.cpu_wdata};

  input_debounce #(
    .IN_WIDTH        (IN_WIDTH),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_input_debounce (
    .clk      (clk),
    .reset    (reset),
    .switches (switches),
    .stable   (w_stable),
    .rise     (w_rise)
  );

  assign w_clr = (w_io_we && (w_off == OFF_STATUS)) ? bus.cpu_wdata[IN_WIDTH-1:0]
                                                    : '0;

  // Register file
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        r_out[i] <= '0;
      end
      r_status <= '0;
      r_enable <= '0;
      r_irq    <= 1'b0;
      r_sel_q  <= 1'b0;
      r_io_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (w_io_we && (w_off == (OFF_OUT + 4'(i)))) begin
          r_out[i] <= bus.cpu_wdata[OUT_WIDTH-1:0];
        end else if (w_io_we && (w_off == (OFF_SET + 4'(i)))) begin
          r_out[i] <= r_out[i] | bus.cpu_wdata[OUT_WIDTH-1:0];
        end
      end
      if (w_io_we && (w_off == OFF_ENABLE)) begin
        r_enable <= bus.cpu_wdata[IN_WIDTH-1:0];
      end
      // Clear first, then OR the new edges so a coincident edge survives.
      r_status <= (r_status & ~w_clr) | w_rise;
      r_irq    <= |(r_status & r_enable);
      // Read pipeline aligned with the BRAM's one-cycle latency; reading
      // STATUS during its own W1C returns the pre-write value.
      r_sel_q  <= w_io_hit;
      r_io_q   <= w_io_data;
    end
  end

  // I/O read mux
  always_comb begin
    w_io_data = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if ((w_off == (OFF_OUT + 4'(i))) || (w_off == (OFF_SET + 4'(i)))) begin
        w_io_data[OUT_WIDTH-1:0] = r_out[i];
      end
    end
    if (w_off == OFF_IN) begin
      w_io_data[IN_WIDTH-1:0] = w_stable;
    end
    if (w_off == OFF_STATUS) begin
      w_io_data[IN_WIDTH-1:0] = r_status;
    end
    if (w_off == OFF_ENABLE) begin
      w_io_data[IN_WIDTH-1:0] = r_enable;
    end
  end

  assign bus.cpu_rdata = r_sel_q ? r_io_q : bus.mem_q;
  assign irq           = r_irq;

  generate
    for (genvar g = 0; g < NUM_OUT; g++) begin : g_leds
      assign leds[g*OUT_WIDTH +: OUT_WIDTH] = r_out[g];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mmio_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_mmio_ctrl                                                 |
// | Purpose : Self-checking bench for mmio_ctrl. Reads push their expected |
// |           data into a scoreboard queue; a monitor pops and compares    |
// |           one cycle later. A small BRAM model supplies mem_q.          |
// | Ports   : none                                                         |
// | Rev     : 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module tb_mmio_ctrl;

  logic        clk      = 1'b0;
  logic        reset    = 1'b0;
  logic [7:0]  switches = 8'h00;
  logic [15:0] leds;
  logic        irq;

  mmio_if #(.WIDTH(16), .ADDR_WIDTH(16)) bus ();

  mmio_ctrl #(
    .WIDTH(16), .ADDR_WIDTH(16), .NUM_OUT(2), .OUT_WIDTH(8),
    .IN_WIDTH(8), .DEBOUNCE_CYCLES(16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .switches (switches),
    .leds     (leds),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] bram [0:255];
  logic        rd_valid = 1'b0;
  logic        rd_d     = 1'b0;
  logic [15:0] exp_q [$];
  string       tag_q [$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // BRAM model: one-cycle read latency, write when the gated enable is high
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) bram[i] <= 16'h0000;
      bram[8'h20] <= 16'h1234;
    end else if (bus.mem_we) begin
      bram[bus.cpu_addr[7:0]] <= bus.cpu_wdata;
    end
    bus.mem_q <= bram[bus.cpu_addr[7:0]];
    rd_d      <= rd_valid;
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rd_d) begin
      if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 32'd1);
      else check(tag_q.pop_front(), 32'(bus.cpu_rdata), 32'(exp_q.pop_front()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d,
                    input logic exp_mem_we, input string tag);
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    bus.cpu_we    = 1'b1;
    rd_valid      = 1'b0;
    @(negedge clk);
    check(tag, 32'(bus.mem_we), 32'(exp_mem_we));
    step();
    bus.cpu_we = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] e, input string tag);
    bus.cpu_addr = a;
    bus.cpu_we   = 1'b0;
    rd_valid     = 1'b1;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    step();
    rd_valid = 1'b0;
  endtask

  initial begin
    bus.cpu_addr  = 16'h0000;
    bus.cpu_wdata = 16'h0000;
    bus.cpu_we    = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check("rst_leds", 32'(leds), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    reset = 1'b1;
    bus.cpu_addr = 16'h0020;
    step();
    @(negedge clk);
    check("rst_rdata_is_mem", 32'(bus.cpu_rdata), 32'h1234);
    step();

    // Output registers and write gating
    wr(16'hC000, 16'h00A5, 1'b0, "mem_we_out0");
    @(negedge clk);
    check("leds_out0", 32'(leds), 32'h00A5);
    step();
    wr(16'hC001, 16'h003C, 1'b0, "mem_we_out1");
    @(negedge clk);
    check("leds_load", 32'(leds), 32'h3CA5);
    step();
    wr(16'h0010, 16'hBEEF, 1'b1, "mem_we_ram");
    rd(16'h0010, 16'hBEEF, "rd_ram_written");

    // Set alias
    wr(16'hC000, 16'h0005, 1'b0, "mem_we_out0b");
    wr(16'hC004, 16'h0050, 1'b0, "mem_we_set");
    @(negedge clk);
    check("leds_set", 32'(leds), 32'h3C55);
    step();
    rd(16'hC004, 16'h0055, "rd_set_alias");
    rd(16'hC000, 16'h0055, "rd_out0");
    rd(16'hC001, 16'h003C, "rd_out1");
    wr(16'hC00F, 16'hFFFF, 1'b0, "mem_we_unmapped");
    @(negedge clk);
    check("leds_unmapped_wr", 32'(leds), 32'h3C55);
    step();

    // Debounce with bounce, enable bit0
    wr(16'hC00A, 16'h0001, 1'b0, "mem_we_enable");
    rd(16'hC00A, 16'h0001, "rd_enable");
    switches[0] = 1'b1; repeat (3) step();
    switches[0] = 1'b0; repeat (3) step();
    switches[0] = 1'b1;
    for (int j = 0; j < 20; j++) begin
      bus.cpu_addr = 16'hC008;
      rd_valid     = 1'b1;
      exp_q.push_back((j >= 18) ? 16'h0001 : 16'h0000);
      tag_q.push_back($sformatf("in_deb_%0d", j));
      @(negedge clk);
      check($sformatf("irq_deb_%0d", j), 32'(irq), 32'(j >= 19));
      step();
    end
    rd_valid = 1'b0;
    rd(16'hC009, 16'h0001, "rd_status_set");

    // Falling edge does not touch STATUS; then W1C collides with a rise
    switches[0] = 1'b0;
    repeat (20) step();
    rd(16'hC008, 16'h0000, "in_fall");
    rd(16'hC009, 16'h0001, "status_sticky");
    switches[0] = 1'b1;
    repeat (17) step();
    wr(16'hC009, 16'h0001, 1'b0, "mem_we_w1c");
    rd(16'hC009, 16'h0001, "status_set_wins");
    @(negedge clk);
    check("irq_hold", 32'(irq), 32'h1);
    step();

    // W1C without an edge, with same-cycle read of STATUS
    bus.cpu_addr  = 16'hC009;
    bus.cpu_wdata = 16'h0001;
    bus.cpu_we    = 1'b1;
    rd_valid      = 1'b1;
    exp_q.push_back(16'h0001);
    tag_q.push_back("rd_status_prewrite");
    step();
    bus.cpu_we = 1'b0;
    rd_valid   = 1'b0;
    @(negedge clk);
    check("irq_before_fall", 32'(irq), 32'h1);
    step();
    @(negedge clk);
    check("irq_fall", 32'(irq), 32'h0);
    step();
    rd(16'hC009, 16'h0000, "status_cleared");

    // Back-to-back mixed reads
    rd(16'h0020, 16'h1234, "alt_ram0");
    rd(16'hC008, 16'h0001, "alt_in0");
    rd(16'h0020, 16'h1234, "alt_ram1");
    rd(16'hC008, 16'h0001, "alt_in1");
    rd(16'hC00F, 16'h0000, "rd_unmapped_f");
    rd(16'hC003, 16'h0000, "rd_unmapped_3");

    // Mid-operation reset
    switches[1] = 1'b1;
    repeat (20) step();
    wr(16'hC00A, 16'h0002, 1'b0, "mem_we_enable2");
    step();
    @(negedge clk);
    check("irq_pre_reset", 32'(irq), 32'h1);
    step();
    switches[2] = 1'b1;
    repeat (8) step();
    bus.cpu_addr = 16'h0020;
    reset = 1'b0;
    step();
    reset = 1'b1;
    for (int j = 0; j < 20; j++) begin
      bus.cpu_addr = 16'hC008;
      rd_valid     = 1'b1;
      exp_q.push_back((j >= 18) ? 16'h0007 : 16'h0000);
      tag_q.push_back($sformatf("in_rst_%0d", j));
      @(negedge clk);
      if (j == 0) begin
        check("rst2_leds", 32'(leds), 32'h0);
        check("rst2_rdata_is_mem", 32'(bus.cpu_rdata), 32'h1234);
      end
      check($sformatf("irq_rst_%0d", j), 32'(irq), 32'h0);
      step();
    end
    rd_valid = 1'b0;
    rd(16'hC009, 16'h0007, "status_after_rst");
    rd(16'hC00A, 16'h0000, "enable_after_rst");
    rd(16'hC001, 16'h0000, "out1_after_rst");

    repeat (2) step();
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
